// File: rtl/xc_malu_core.sv
// ---------------------------------------------------------------------------
// xc_malu_core
//   Multi-cycle multiply / divide / accumulate unit for the XCrypto execute
//   stage. One operation is in flight at a time. The issuer holds operands
//   and the one-hot micro-op stable while valid && !ready, then pulses flush
//   in the cycle it consumes the result.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   rs1, rs2, rs3 [31:0]  : source operands
//   flush                 : result consumed, return to idle (highest priority)
//   valid                 : operands and micro-op are valid
//   uop_*                 : one-hot operation select
//   pw_*                  : one-hot packed lane width (pmul / pclmul only)
//   result [63:0]         : operation result, stable while ready is high
//   ready                 : result is valid (registered)
//
// Latency from the first valid cycle to ready:
//   madd/msub/macc : 1    (computed from live operands on the capture edge)
//   multiplies     : 32   (bit 0 on the capture edge, bits 1..31 in BUSY)
//   divide/rem     : 34   (abs on capture, 32 restoring steps, sign fix-up)
// ---------------------------------------------------------------------------
module xc_malu_core (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] rs3,
  input  logic        flush,
  input  logic        valid,
  input  logic        uop_div,
  input  logic        uop_divu,
  input  logic        uop_rem,
  input  logic        uop_remu,
  input  logic        uop_mul,
  input  logic        uop_mulu,
  input  logic        uop_mulsu,
  input  logic        uop_clmul,
  input  logic        uop_pmul,
  input  logic        uop_pclmul,
  input  logic        uop_madd,
  input  logic        uop_msub,
  input  logic        uop_macc,
  input  logic        uop_mmul,
  input  logic        pw_32,
  input  logic        pw_16,
  input  logic        pw_8,
  input  logic        pw_4,
  input  logic        pw_2,
  output logic [63:0] result,
  output logic        ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  typedef enum logic [3:0] {
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MUL, OP_MULU, OP_MULSU, OP_CLMUL, OP_PMUL, OP_PCLMUL,
    OP_MADD, OP_MSUB, OP_MACC, OP_MMUL
  } op_e;

  // Packed products are accumulated in two 64-bit halves: even lanes in e,
  // odd lanes in o. Lane i's 2w-bit product sits at bit i*w of its half, so
  // lanes sharing a half never overlap. Full-width ops use e only; the
  // divider reuses e as the partial remainder and o as the quotient shifter.
  typedef struct packed {
    logic [63:0] e;
    logic [63:0] o;
  } acc_t;

  // lg is log2 of the lane width: 1..4 for packed widths, 5 for 32 bits.
  function automatic logic [63:0] a_extend(input logic [31:0] a, input logic sgn);
    return sgn ? {{32{a[31]}}, a} : {32'd0, a};
  endfunction

  // Partial product for multiplier bit j: the multiplicand restricted to the
  // lane that owns bit j, shifted by j's position inside that lane.
  function automatic logic [63:0] mul_term(input logic [63:0] a_ext,
                                           input logic [4:0]  j,
                                           input logic [2:0]  lg);
    logic [63:0] m;
    int          k;
    m = a_ext;
    for (int p = 0; p < 32; p++) begin
      if ((p >> lg) != (int'(j) >> lg)) m[p] = 1'b0;
    end
    if (lg != 3'd5) m[63:32] = 32'd0;
    k = int'(j) & ((1 << lg) - 1);
    return m << k;
  endfunction

  // One shift-add step. For a signed multiplier the weight of bit 31 is
  // -2^31, so that final partial product is subtracted instead of added.
  function automatic acc_t mul_step(input acc_t        acc,
                                    input logic [63:0] a_ext,
                                    input logic [31:0] b,
                                    input logic [4:0]  j,
                                    input logic [2:0]  lg,
                                    input logic        clmul,
                                    input logic        neg_last);
    acc_t        r;
    logic [63:0] t;
    logic        odd;
    r   = acc;
    t   = mul_term(a_ext, j, lg);
    odd = (lg != 3'd5) && (((int'(j) >> lg) & 1) != 0);
    if (b[j]) begin
      if (odd)                         r.o = clmul ? (r.o ^ t) : (r.o + t);
      else if (clmul)                  r.e = r.e ^ t;
      else if (neg_last && j == 5'd31) r.e = r.e - t;
      else                             r.e = r.e + t;
    end
    return r;
  endfunction

  // Low halves of the lane products fill result[31:0], high halves fill
  // result[63:32], each at its lane offset.
  function automatic logic [63:0] repack(input acc_t acc, input logic [2:0] lg);
    logic [63:0] r;
    logic [63:0] src;
    int          w;
    w = 1 << lg;
    r = '0;
    for (int p = 0; p < 32; p++) begin
      src       = (((p >> lg) & 1) != 0) ? acc.o : acc.e;
      r[p]      = src[p];
      r[32 + p] = src[p + w];
    end
    return r;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (32'd0 - x) : x;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e      state_q,  state_d;
  op_e         op_q,     op_d;
  logic [2:0]  lg_q,     lg_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [31:0] op_a_q,   op_a_d;
  logic [31:0] op_b_q,   op_b_d;
  acc_t        acc_q,    acc_d;
  logic [63:0] result_q, result_d;
  logic        ready_q,  ready_d;

  // ---------------------------------------------------------------------
  // Decode of the live micro-op and lane width
  // ---------------------------------------------------------------------
  op_e        op_in;
  logic [2:0] lg_in;

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    op_in = OP_MADD;
    if      (uop_div)    op_in = OP_DIV;
    else if (uop_divu)   op_in = OP_DIVU;
    else if (uop_rem)    op_in = OP_REM;
    else if (uop_remu)   op_in = OP_REMU;
    else if (uop_mul)    op_in = OP_MUL;
    else if (uop_mulu)   op_in = OP_MULU;
    else if (uop_mulsu)  op_in = OP_MULSU;
    else if (uop_clmul)  op_in = OP_CLMUL;
    else if (uop_pmul)   op_in = OP_PMUL;
    else if (uop_pclmul) op_in = OP_PCLMUL;
    else if (uop_madd)   op_in = OP_MADD;
    else if (uop_msub)   op_in = OP_MSUB;
    else if (uop_macc)   op_in = OP_MACC;
    else if (uop_mmul)   op_in = OP_MMUL;

    lg_in = 3'd5;
    if (uop_pmul || uop_pclmul) begin
      if      (pw_32) lg_in = 3'd5;
      else if (pw_16) lg_in = 3'd4;
      else if (pw_8)  lg_in = 3'd3;
      else if (pw_4)  lg_in = 3'd2;
      else if (pw_2)  lg_in = 3'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Single-cycle multi-precision ops, from live operands
  // ---------------------------------------------------------------------
  logic [32:0] madd_sum;
  logic [32:0] msub_dif;
  logic [63:0] single_res;

  always_comb begin
    madd_sum = {1'b0, rs1} + {1'b0, rs2} + {32'd0, rs3[0]};
    msub_dif = {1'b0, rs1} - {1'b0, rs2} - {32'd0, rs3[0]};
    case (op_in)
      OP_MADD: single_res = {31'd0, madd_sum};
      OP_MSUB: single_res = {31'd0, msub_dif};
      default: single_res = {rs1, rs2} + {32'd0, rs3};
    endcase
  end

  // ---------------------------------------------------------------------
  // Multiplier: first step on the capture edge, remaining steps in BUSY
  // ---------------------------------------------------------------------
  logic in_signed_a, in_clmul, q_signed_a, q_clmul;
  acc_t mul_init, mul_cap, mul_next;

  always_comb begin
    in_signed_a = (op_in == OP_MUL) || (op_in == OP_MULSU);
    in_clmul    = (op_in == OP_CLMUL) || (op_in == OP_PCLMUL);
    q_signed_a  = (op_q == OP_MUL) || (op_q == OP_MULSU);
    q_clmul     = (op_q == OP_CLMUL) || (op_q == OP_PCLMUL);

    // mmul folds the addend in by seeding the accumulator with rs3.
    mul_init.e  = (op_in == OP_MMUL) ? {32'd0, rs3} : 64'd0;
    mul_init.o  = 64'd0;

    mul_cap  = mul_step(mul_init, a_extend(rs1, in_signed_a), rs2, 5'd0,
                        lg_in, in_clmul, op_in == OP_MUL);
    mul_next = mul_step(acc_q, a_extend(op_a_q, q_signed_a), op_b_q,
                        cnt_q[4:0] + 5'd1, lg_q, q_clmul, op_q == OP_MUL);
  end

  // ---------------------------------------------------------------------
  // Restoring divider on magnitudes, sign fix-up at the end
  // ---------------------------------------------------------------------
  logic        in_div_signed, q_div_signed;
  logic [31:0] dividend_in;
  logic [31:0] divisor;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  acc_t        div_next;
  logic        neg_a, neg_b;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] div_result;

  always_comb begin
    in_div_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    dividend_in   = in_div_signed ? abs32(rs1) : rs1;

    q_div_signed  = (op_q == OP_DIV) || (op_q == OP_REM);
    divisor       = q_div_signed ? abs32(op_b_q) : op_b_q;

    rem_sh   = {acc_q.e[31:0], acc_q.o[31]};
    div_diff = {1'b0, rem_sh} - {2'd0, divisor};
    if (!div_diff[33]) begin
      div_next.e = {31'd0, div_diff[32:0]};
      div_next.o = {32'd0, acc_q.o[30:0], 1'b1};
    end else begin
      div_next.e = {31'd0, rem_sh};
      div_next.o = {32'd0, acc_q.o[30:0], 1'b0};
    end

    neg_a = q_div_signed & op_a_q[31];
    neg_b = q_div_signed & op_b_q[31];
    if (op_b_q == 32'd0) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = op_a_q;
    end else begin
      quo_fix = (neg_a ^ neg_b) ? (32'd0 - acc_q.o[31:0]) : acc_q.o[31:0];
      rem_fix = neg_a ? (32'd0 - acc_q.e[31:0]) : acc_q.e[31:0];
    end
    div_result = {32'd0, ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fix : rem_fix};
  end

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  logic abort;
  logic in_single, in_div, q_div;

  always_comb begin
    abort     = flush || (!valid && state_q != ST_IDLE);
    in_single = (op_in == OP_MADD) || (op_in == OP_MSUB) || (op_in == OP_MACC);
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU) ||
                (op_in == OP_REM) || (op_in == OP_REMU);
    q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                (op_q == OP_REM) || (op_q == OP_REMU);

    state_d  = state_q;
    op_d     = op_q;
    lg_d     = lg_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    ready_d  = ready_q;

    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = 6'd0;
      acc_d    = '0;
      result_d = 64'd0;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_d  = 1'b0;
          result_d = 64'd0;
          if (valid) begin
            op_d   = op_in;
            lg_d   = lg_in;
            op_a_d = rs1;
            op_b_d = rs2;
            cnt_d  = 6'd0;
            if (in_single) begin
              acc_d    = '0;
              result_d = single_res;
              ready_d  = 1'b1;
              state_d  = ST_DONE;
            end else if (in_div) begin
              acc_d.e = 64'd0;
              acc_d.o = {32'd0, dividend_in};
              state_d = ST_BUSY;
            end else begin
              acc_d   = mul_cap;
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q + 6'd1;
          if (q_div) begin
            if (cnt_q == 6'd32) begin
              result_d = div_result;
              ready_d  = 1'b1;
              state_d  = ST_DONE;
            end else begin
              acc_d = div_next;
            end
          end else begin
            acc_d = mul_next;
            if (cnt_q == 6'd30) begin
              result_d = repack(mul_next, lg_q);
              ready_d  = 1'b1;
              state_d  = ST_DONE;
            end
          end
        end
        ST_DONE: ;  // hold result and ready until flush or valid drops
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, whatever the statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MADD;
      lg_q     <= 3'd5;
      cnt_q    <= 6'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      acc_q    <= '0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lg_q     <= lg_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_xc_malu_core.sv
// ---------------------------------------------------------------------------
// tb_xc_malu_core
//   Self-checking bench for xc_malu_core. Expected results come from an
//   arithmetic reference model of each operation; expected latencies from the
//   per-class latency table. Directed corner cases are followed by a random
//   stream mixing back-to-back ops, idle gaps, aborts and resets.
// ---------------------------------------------------------------------------
module tb_xc_malu_core;

  // Operation indices match the uop bit order below.
  localparam int DIV = 0, DIVU = 1, REM = 2, REMU = 3, MUL = 4, MULU = 5,
                 MULSU = 6, CLMUL = 7, PMUL = 8, PCLMUL = 9, MADD = 10,
                 MSUB = 11, MACC = 12, MMUL = 13;

  logic        clock;
  logic        reset;
  logic [31:0] rs1, rs2, rs3;
  logic        flush;
  logic        valid;
  logic [13:0] uop;
  logic [4:0]  pw;   // [0]=2, [1]=4, [2]=8, [3]=16, [4]=32
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  xc_malu_core dut (
    .clock      (clock),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs3        (rs3),
    .flush      (flush),
    .valid      (valid),
    .uop_div    (uop[0]),
    .uop_divu   (uop[1]),
    .uop_rem    (uop[2]),
    .uop_remu   (uop[3]),
    .uop_mul    (uop[4]),
    .uop_mulu   (uop[5]),
    .uop_mulsu  (uop[6]),
    .uop_clmul  (uop[7]),
    .uop_pmul   (uop[8]),
    .uop_pclmul (uop[9]),
    .uop_madd   (uop[10]),
    .uop_msub   (uop[11]),
    .uop_macc   (uop[12]),
    .uop_mmul   (uop[13]),
    .pw_32      (pw[4]),
    .pw_16      (pw[3]),
    .pw_8       (pw[2]),
    .pw_4       (pw[1]),
    .pw_2       (pw[0]),
    .result     (result),
    .ready      (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic logic [63:0] ref_clmul(input logic [63:0] x, input logic [63:0] y,
                                            input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) if (y[i]) r = r ^ (x << i);
    return r;
  endfunction

  function automatic logic [63:0] ref_model(input int op, input int lg,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
    int          sa, sb, w;
    logic [31:0] q;
    longint      x, y;
    logic [63:0] mask, xa, xb, p, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      DIV: begin
        if (b == 0) q = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) q = 32'h8000_0000;
        else q = sa / sb;
        r = {32'd0, q};
      end
      DIVU: r = (b == 0) ? 64'h0000_0000_FFFF_FFFF : {32'd0, a / b};
      REM: begin
        if (b == 0) q = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) q = 32'd0;
        else q = sa % sb;
        r = {32'd0, q};
      end
      REMU: r = (b == 0) ? {32'd0, a} : {32'd0, a % b};
      MUL: begin
        x = $signed(a); y = $signed(b); r = x * y;
      end
      MULU:  r = {32'd0, a} * {32'd0, b};
      MULSU: begin
        x = $signed(a); y = {32'd0, b}; r = x * y;
      end
      CLMUL: r = ref_clmul({32'd0, a}, {32'd0, b}, 32);
      PMUL, PCLMUL: begin
        w    = 1 << lg;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < 32 / w; i++) begin
          xa = ({32'd0, a} >> (i * w)) & mask;
          xb = ({32'd0, b} >> (i * w)) & mask;
          p  = (op == PMUL) ? xa * xb : ref_clmul(xa, xb, w);
          r  = r | ((p & mask) << (i * w));
          r  = r | (((p >> w) & mask) << (32 + i * w));
        end
      end
      MADD: r = {32'd0, a} + {32'd0, b} + {63'd0, c[0]};
      MSUB: r = ({32'd0, a} - {32'd0, b} - {63'd0, c[0]}) & 64'h1_FFFF_FFFF;
      MACC: r = {a, b} + {32'd0, c};
      default: r = {32'd0, a} * {32'd0, b} + {32'd0, c};
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input int op);
    if (op <= REMU) return 34;
    if (op == MADD || op == MSUB || op == MACC) return 1;
    return 32;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus helpers (called at posedge + 1)
  // ---------------------------------------------------------------------
  task automatic drive(input int op, input int lg,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    uop   = 14'(1 << op);
    pw    = 5'(1 << (lg - 1));
    rs1   = a;
    rs2   = b;
    rs3   = c;
    valid = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40 && !ready) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  // Runs one op to completion, then flushes; valid is left high so the next
  // call starts in the cycle right after the flush edge.
  task automatic run_op(input int op, input int lg,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int n;
    drive(op, lg, a, b, c);
    wait_ready(n);
    check($sformatf("latency op%0d", op), 64'(n), 64'(ref_latency(op)));
    check($sformatf("result op%0d lg%0d %h %h %h", op, lg, a, b, c),
          result, ref_model(op, lg, a, b, c));
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("ready after flush", {63'd0, ready}, 64'd0);
  endtask

  task automatic abort_op(input int op, input int lg, input logic [31:0] a,
                          input logic [31:0] b, input int k);
    drive(op, lg, a, b, 32'd0);
    repeat (k) @(posedge clock);
    #1;
    check("ready before abort", {63'd0, ready}, 64'd0);
    valid = 1'b0;
    @(posedge clock); #1;
    check("ready after abort", {63'd0, ready}, 64'd0);
    check("result after abort", result, 64'd0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    int op, lg, n;
    reset = 1'b1; valid = 1'b0; flush = 1'b0;
    uop = '0; pw = '0; rs1 = '0; rs2 = '0; rs3 = '0;
    #12;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Directed corners, issued back-to-back
    run_op(DIVU,   5, 32'd100,        32'd7,          32'd0);
    check("divu 100/7 const", ref_model(DIVU, 5, 32'd100, 32'd7, 32'd0), 64'h0E);
    run_op(DIV,    5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    run_op(REM,    5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    run_op(REM,    5, 32'd5,          32'd0,          32'd0);
    run_op(DIVU,   5, 32'h1234_5678,  32'd0,          32'd0);
    run_op(DIV,    5, 32'hFFFF_FFF9,  32'd0,          32'd0);
    run_op(REM,    5, 32'hFFFF_FFF9,  32'd2,          32'd0);
    run_op(DIV,    5, 32'hFFFF_FFF9,  32'd2,          32'd0);
    run_op(MUL,    5, 32'hFFFF_FFFF,  32'd2,          32'd0);
    run_op(MUL,    5, 32'h8000_0000,  32'h8000_0000,  32'd0);
    run_op(MULSU,  5, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0);
    run_op(CLMUL,  5, 32'd3,          32'd3,          32'd0);
    run_op(PMUL,   3, 32'hFF02_FF03,  32'h02FF_0304,  32'd0);
    run_op(PCLMUL, 1, 32'hFF02_FF03,  32'h02FF_0304,  32'd0);
    run_op(PMUL,   5, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0);
    run_op(MADD,   5, 32'hFFFF_FFFF,  32'd1,          32'd1);
    run_op(MSUB,   5, 32'd0,          32'd1,          32'd0);
    run_op(MACC,   5, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1);
    run_op(MMUL,   5, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    valid = 1'b0;
    @(posedge clock); #1;
    check("idle ready", {63'd0, ready}, 64'd0);

    // Reset while holding a finished result clears it at once
    drive(MADD, 5, 32'd1, 32'd2, 32'd0);
    @(posedge clock); #1;
    check("madd ready", {63'd0, ready}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset ready", {63'd0, ready}, 64'd0);
    check("async reset result", result, 64'd0);
    @(negedge clock) begin reset = 1'b0; valid = 1'b0; end
    @(posedge clock); #1;

    // Random stream: back-to-back, idle gaps and aborts
    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 13);
      lg = (op == PMUL || op == PCLMUL) ? $urandom_range(1, 5) : 5;
      case ($urandom_range(0, 9))
        0: begin
          if (ref_latency(op) > 1)
            abort_op(op, lg, rnd32(), rnd32(), $urandom_range(1, ref_latency(op) - 1));
          else
            run_op(op, lg, rnd32(), rnd32(), rnd32());
        end
        1: begin
          valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clock);
          #1;
          check("gap ready", {63'd0, ready}, 64'd0);
          run_op(op, lg, rnd32(), rnd32(), rnd32());
        end
        default: run_op(op, lg, rnd32(), rnd32(), rnd32());
      endcase
    end

    // Reset in the middle of a divide, then a clean divide
    valid = 1'b0;
    @(posedge clock); #1;
    drive(DIV, 5, 32'hDEAD_BEEF, 32'd12345, 32'd0);
    repeat (15) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("mid-div reset ready", {63'd0, ready}, 64'd0);
    check("mid-div reset result", result, 64'd0);
    @(negedge clock) begin reset = 1'b0; valid = 1'b0; end
    @(posedge clock); #1;
    run_op(DIV, 5, 32'hDEAD_BEEF, 32'd12345, 32'd0);
    valid = 1'b0;
    @(posedge clock); #1;
    wait_ready(n);
    check("no spurious ready", {63'd0, ready}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
